// File: rtl/captura_pkg.sv
// captura_pkg: shared state encoding and default operand width for the serial capture block
package captura_pkg;
  localparam int ANCHO_DEF = 8;
  typedef enum logic [1:0] {CAP_A = 2'd0, CAP_B = 2'd1, CAP_C = 2'd2, PRESENT = 2'd3} estado_t;
endpackage

// File: rtl/registro_desplazamiento.sv
// registro_desplazamiento: LSB-first serial-in/parallel-out shift register with enable and clear
module registro_desplazamiento #(
  parameter int ANCHO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             d_i,
  output logic [ANCHO-1:0] q_o
);
  logic [ANCHO-1:0] q_q;
  // new bits enter at the top so the first of ANCHO bits ends up in bit 0
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= '0;
    else if (clr_i) q_q <= '0;
    else if (en_i) q_q <= (ANCHO > 1) ? {d_i, q_q[ANCHO-1:1]} : ANCHO'(d_i);
  assign q_o = q_q;
endmodule

// File: rtl/captura_serial.sv
// captura_serial: gathers A, B and carry-in from a serial stream and presents them to an adder
module captura_serial
  import captura_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             inicio,
  output logic [ANCHO-1:0] a,
  output logic [ANCHO-1:0] b,
  output logic             cin,
  output logic             op_valid,
  input  logic             op_ready
);
  localparam int CW = $clog2(ANCHO + 1);
  estado_t          state_q;
  logic [CW-1:0]    cnt_q;
  logic [ANCHO-1:0] a_q, b_q, sa, sb;
  logic             cin_q, op_valid_q, acc, ultimo;
  assign din_ready = (state_q != PRESENT);
  assign acc       = din_valid & din_ready & ~inicio;
  assign ultimo    = (cnt_q == CW'(ANCHO - 1));
  registro_desplazamiento #(.ANCHO(ANCHO)) u_ra (
    .clk(clk), .rst(rst), .clr_i(inicio), .en_i(acc && state_q == CAP_A), .d_i(din), .q_o(sa)
  );
  registro_desplazamiento #(.ANCHO(ANCHO)) u_rb (
    .clk(clk), .rst(rst), .clr_i(inicio), .en_i(acc && state_q == CAP_B), .d_i(din), .q_o(sb)
  );
  // frame sequencing; operand outputs load only when PRESENT is entered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= CAP_A;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      op_valid_q <= 1'b0;
    end else if (inicio) begin
      state_q    <= CAP_A;
      cnt_q      <= '0;
      op_valid_q <= 1'b0;
    end else if (acc && (state_q == CAP_A || state_q == CAP_B)) begin
      cnt_q <= ultimo ? '0 : cnt_q + 1'b1;
      if (ultimo) state_q <= (state_q == CAP_A) ? CAP_B : CAP_C;
    end else if (acc && state_q == CAP_C) begin
      a_q        <= sa;
      b_q        <= sb;
      cin_q      <= din;
      op_valid_q <= 1'b1;
      state_q    <= PRESENT;
    end else if (state_q == PRESENT && op_ready) begin
      state_q    <= CAP_A;
      cnt_q      <= '0;
      op_valid_q <= 1'b0;
    end
  assign a        = a_q;
  assign b        = b_q;
  assign cin      = cin_q;
  assign op_valid = op_valid_q;
endmodule

// File: tb/tb_captura_serial.sv
// tb_captura_serial: directed and randomized checks of serial operand capture
module tb_captura_serial;
  logic       clk = 1'b0, rst = 1'b1, din = 1'b0, din_valid = 1'b0, inicio = 1'b0, op_ready = 1'b1;
  logic       din_ready, cin, op_valid;
  logic [7:0] a, b;
  int         n_cmp = 0, n_bad = 0, cyc = 0, t1 = 0;
  logic [8:0] suma;

  captura_serial #(.ANCHO(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .inicio(inicio), .a(a), .b(b), .cin(cin), .op_valid(op_valid), .op_ready(op_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] fa, input logic [7:0] fb, input logic fc, input int i);
    return (i < 8) ? fa[i] : (i < 16) ? fb[i-8] : fc;
  endfunction

  // mode 0: back-to-back bits, 1: idle cycle before every bit, 2: random idle cycles
  task automatic send_bits(input logic [7:0] fa, input logic [7:0] fb, input logic fc,
                           input int mode, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        din_valid = 1'b0;
        din = 1'($urandom);
        step();
      end
      din = frame_bit(fa, fb, fc, i);
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
  endtask

  task automatic present(input string tag, input logic [7:0] fa, input logic [7:0] fb,
                         input logic fc, input int waits);
    for (int k = 0; k < waits; k++) begin
      op_ready = 1'b0;
      chk({tag, "_hold_valid"}, 32'(op_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(din_ready), 32'd0);
      chk({tag, "_hold_abc"}, {15'd0, cin, a, b}, {15'd0, fc, fa, fb});
      step();
    end
    op_ready = 1'b1;
    chk({tag, "_valid"}, 32'(op_valid), 32'd1);
    chk({tag, "_abc"}, {15'd0, cin, a, b}, {15'd0, fc, fa, fb});
    step();
    chk({tag, "_drop"}, 32'(op_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    int         w;
    step();
    chk("rst_abc", {15'd0, cin, a, b}, 32'd0);
    chk("rst_valid", 32'(op_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(din_ready), 32'd1);

    send_bits(8'hA5, 8'h3C, 1'b1, 0, 17);
    t1 = cyc;
    suma = 9'(a) + 9'(b) + 9'(cin);
    chk("f1_sum", 32'(suma), 32'h0E2);
    present("f1", 8'hA5, 8'h3C, 1'b1, 0);

    send_bits(8'hFF, 8'h01, 1'b0, 1, 17);
    suma = 9'(a) + 9'(b) + 9'(cin);
    chk("f2_sum", 32'(suma), 32'h100);
    present("f2", 8'hFF, 8'h01, 1'b0, 0);

    send_bits(8'h5A, 8'hC3, 1'b1, 0, 17);
    present("bp", 8'h5A, 8'hC3, 1'b1, 5);

    send_bits(8'h77, 8'hEE, 1'b1, 0, 11);
    chk("ab_novalid", 32'(op_valid), 32'd0);
    inicio = 1'b1;
    din = 1'b1;
    din_valid = 1'b1;
    step();
    inicio = 1'b0;
    din_valid = 1'b0;
    chk("ab_ready", 32'(din_ready), 32'd1);
    send_bits(8'h12, 8'h34, 1'b0, 0, 17);
    present("ab", 8'h12, 8'h34, 1'b0, 0);

    send_bits(8'hAA, 8'h55, 1'b1, 0, 10);
    rst = 1'b1;
    #1;
    chk("rst_mid_abc", {15'd0, cin, a, b}, 32'd0);
    chk("rst_mid_valid", 32'(op_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    send_bits(8'h0F, 8'hF0, 1'b1, 0, 17);
    present("rs", 8'h0F, 8'hF0, 1'b1, 0);

    send_bits(8'h81, 8'h7E, 1'b0, 0, 17);
    t1 = cyc;
    chk("b2b_v1", 32'(op_valid), 32'd1);
    step();
    send_bits(8'h3D, 8'hC2, 1'b1, 0, 17);
    chk("b2b_gap", 32'(cyc - t1), 32'd18);
    present("b2b", 8'h3D, 8'hC2, 1'b1, 0);

    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      w = $urandom_range(0, 3);
      send_bits(ra, rb, rc, 2, 17);
      present("rnd", ra, rb, rc, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/captura_serial.md
CAPTURA_SERIAL -- requirements
Module: captura_serial

Interface
REQ-001 SHALL have parameter ANCHO, default 8, giving the operand width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port din  input  1  serial operand bit, LSB first.
REQ-005 SHALL have port din_valid  input  1  din carries a valid bit this cycle.
REQ-006 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-007 SHALL have port inicio  input  1  synchronous frame restart pulse.
REQ-008 SHALL have port a  output  ANCHO  captured operand A, to the adder.
REQ-009 SHALL have port b  output  ANCHO  captured operand B, to the adder.
REQ-010 SHALL have port cin  output  1  captured carry-in, to the adder.
REQ-011 SHALL have port op_valid  output  1  a/b/cin form a complete operand set.
REQ-012 SHALL have port op_ready  input  1  downstream consumes the operand set.

Function
REQ-013 SHALL implement states CAP_A, CAP_B, CAP_C, PRESENT.
REQ-014 SHALL accept a bit only when din_valid and din_ready are both 1 in the same cycle.
REQ-015 SHALL drive din_ready=1 in CAP_A/CAP_B/CAP_C and din_ready=0 in PRESENT.
REQ-016 SHALL shift accepted bits LSB first into the internal A shift register in CAP_A and the internal B shift register in CAP_B, so the first accepted bit lands in bit 0.
REQ-017 SHALL count accepted bits 0..ANCHO-1, moving CAP_A->CAP_B and CAP_B->CAP_C on the ANCHO-th bit and clearing the counter.
REQ-018 SHALL leave state and counter unchanged in cycles with no accepted bit.
REQ-019 SHALL, in CAP_C, store the one accepted bit as cin and move to PRESENT.
REQ-020 SHALL load a, b and cin from the internal registers only on entry to PRESENT; they remain stable while op_valid=1.
REQ-021 SHALL assert op_valid=1 exactly when in PRESENT, from the cycle after the (2*ANCHO+1)-th accepted bit.
REQ-022 SHALL, on op_valid and op_ready both 1, complete the transfer, return to CAP_A with counter 0 and drive op_valid=0 next cycle.
REQ-023 SHALL hold PRESENT indefinitely while op_ready=0.
REQ-024 SHALL, on inicio=1, go to CAP_A next cycle, clear the counter and internal shift registers, drop op_valid and discard that cycle's din.
REQ-025 SHALL, if inicio=1 and op_valid and op_ready are all 1 in the same cycle, still count the transfer as completed.
REQ-026 SHALL retain the last transferred a/b/cin values on the outputs until the next entry to PRESENT.

Reset
REQ-027 SHALL, while rst=1, force CAP_A, counter 0, internal registers 0, a=0, b=0, cin=0 and op_valid=0.
REQ-028 SHALL abandon any partial frame on reset mid-capture, with reset values driven immediately rather than at the next clk edge.

Structure
REQ-029 SHALL take state encoding constants and the ANCHO default from shared package captura_pkg.
REQ-030 SHALL instantiate sub-module registro_desplazamiento (ANCHO-bit serial-in/parallel-out with enable and clear) twice, once for A and once for B.

Verification
REQ-031 SHALL cover: A=0xA5, B=0x3C, cin=1 sent in 17 consecutive valid cycles with op_ready=1 -> op_valid high one cycle, a=0xA5, b=0x3C, cin=1; adder s=0xE2, cout=0.
REQ-032 SHALL cover: A=0xFF, B=0x01, cin=0 sent with din_valid low every other cycle -> same capture, a=0xFF, b=0x01, cin=0; adder s=0x00, cout=1.
REQ-033 SHALL cover backpressure: op_ready=0 for 5 cycles after op_valid -> a/b/cin stable, din_ready=0 throughout, transfer on cycle 6.
REQ-034 SHALL cover inicio asserted after 3 bits of B -> next frame A=0x12, B=0x34, cin=0 captured exactly, with no residue from the aborted frame.
REQ-035 SHALL cover rst pulsed after 10 accepted bits -> outputs 0 immediately, then the full frame A=0x0F, B=0xF0, cin=1 is captured correctly.
REQ-036 SHALL cover two back-to-back frames with op_ready=1 -> second op_valid exactly 18 cycles after the first, with no lost bits.
